// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS main controller and the shared datapath.
//   instr_op      opcode field of the instruction register (bits 31:26)
//   mem_ready     memory completes the current access this cycle
//   pc_write .. pc_source   datapath mux selects and enables
//   illegal_op    one-cycle pulse on an unsupported opcode
//   state_dbg     current controller state encoding
//   instr_count   retired-instruction counter
// master: controller side; slave: datapath / environment side.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       instr_op;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic [3:0]       state_dbg;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  instr_op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
           state_dbg, instr_count
  );

  modport slave (
    output instr_op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
           state_dbg, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller FSM. Sequences the shared memory, ALU, register file and PC
// over several cycles per instruction and counts retired instructions.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    multicycle_control_if.master (opcode/mem_ready in, control selects out)
// Optional feature: define MULTICYCLE_ADDI_EN to build the addi states (ADDI_EXEC/ADDI_WB);
// without it opcode 001000 is treated as illegal.
module multicycle_control #(
  parameter int unsigned CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpJ   = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OpAddi = 6'b001000;
`endif

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRd    = 4'd4,
    StMemWb    = 4'd5,
    StMemWr    = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10
`ifdef MULTICYCLE_ADDI_EN
    , StAddiExec = 4'd11
    , StAddiWb   = 4'd12
`endif
  } state_e;

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_retire;

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = StFetch;
    unique case (r_state)
      StIdle:    w_next_state = StFetch;
      StFetch:   w_next_state = bus.mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (bus.instr_op)
          OpR:        w_next_state = StRExec;
          OpLw, OpSw: w_next_state = StMemAddr;
          OpBeq:      w_next_state = StBranch;
          OpJ:        w_next_state = StJump;
`ifdef MULTICYCLE_ADDI_EN
          OpAddi:     w_next_state = StAddiExec;
`endif
          default:    w_next_state = StFetch;
        endcase
      end
      StMemAddr: w_next_state = (bus.instr_op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   w_next_state = bus.mem_ready ? StMemWb : StMemRd;
      StMemWr:   w_next_state = bus.mem_ready ? StFetch : StMemWr;
      StRExec:   w_next_state = StRWb;
`ifdef MULTICYCLE_ADDI_EN
      StAddiExec: w_next_state = StAddiWb;
`endif
      default:   w_next_state = StFetch;
    endcase
  end

  // Output decode: Moore except FETCH enables (qualified by mem_ready) and the DECODE illegal flag
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.illegal_op    = 1'b0;
    w_retire          = 1'b0;
    unique case (r_state)
      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      StDecode: begin
        bus.alu_src_b = 2'b11;
        // Any opcode that falls back to FETCH from DECODE is unsupported
        bus.illegal_op = (w_next_state == StFetch);
      end
      StMemAddr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      StMemRd: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      StMemWb: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        w_retire       = 1'b1;
      end
      StMemWr: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        w_retire      = bus.mem_ready;
      end
      StRExec: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      StRWb: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        w_retire      = 1'b1;
      end
      StBranch: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        w_retire          = 1'b1;
      end
      StJump: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        w_retire      = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      StAddiExec: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      StAddiWb: begin
        bus.reg_write = 1'b1;
        w_retire      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.state_dbg   = r_state;
  assign bus.instr_count = r_instr_count;

endmodule
